// File: rtl/uart_fifo_core_pkg.sv
// rtl/uart_fifo_core_pkg.sv - shared constants, FSM state types and sizing helper for the UART core
package uart_fifo_core_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo_core_byte_fifo.sv
// rtl/uart_fifo_core_byte_fifo.sv - first-word fall-through byte queue with occupancy counter
module byte_fifo
    import uart_fifo_core_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 empty,
    output logic                 full
);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot the push needs, so a full queue still accepts it.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - buffered 8N1 UART: RX synchroniser and deserialiser, TX serialiser, two byte queues
module uart_fifo_core
    import uart_fifo_core_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int QDEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_we,
    input  logic [DATA_BITS-1:0] tx_wdata,
    output logic                 tx_full,
    input  logic                 rx_re,
    output logic [DATA_BITS-1:0] rx_rdata,
    output logic                 rx_ready,
    output logic                 rx_full,
    output logic                 busy
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic [1:0] rx_sync;
    logic       rx_s;
    logic       rx_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
        end
    end
    assign rx_s = rx_sync[1];

    rx_state_t            rx_state, rx_state_d;
    logic [CW-1:0]        rx_cnt, rx_cnt_d;
    logic [2:0]           rx_bit, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
    logic                 rx_push, rx_push_d;
    logic                 rx_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_push  <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            rx_push  <= rx_push_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt + CW'(1);
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_push_d  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == LAST_BIT) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // A low stop bit is a framing error: the byte is simply not queued.
                if (rx_cnt == BIT_LAST) begin
                    rx_push_d  = rx_s;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    byte_fifo #(.DEPTH(QDEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rx_re),
        .rdata (rx_rdata),
        .empty (rx_empty),
        .full  (rx_full)
    );
    assign rx_ready = !rx_empty;

    tx_state_t            tx_state, tx_state_d;
    logic [CW-1:0]        tx_cnt, tx_cnt_d;
    logic [2:0]           tx_bit, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
    logic                 tx_d;
    logic                 tx_pop;
    logic                 tx_empty;
    logic [DATA_BITS-1:0] tx_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + CW'(1);
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_d       = tx;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit == LAST_BIT) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit + 3'd1;
                        tx_d       = tx_shift[1];
                        tx_shift_d = {1'b1, tx_shift[DATA_BITS-1:1]};
                    end
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit so queued frames leave with no idle gap.
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_d       = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    byte_fifo #(.DEPTH(QDEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_we),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );
    assign busy = (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - directed self-checking bench for uart_fifo_core at 16 clocks per bit
module tb_uart_fifo_core;
    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int QDEPTH = 16;
    localparam int CPB    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       tx_we = 1'b0;
    logic [7:0] tx_wdata = 8'h00;
    logic       rx_re = 1'b0;
    logic       rx_line;
    logic       tx;
    logic       tx_full;
    logic [7:0] rx_rdata;
    logic       rx_ready;
    logic       rx_full;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .QDEPTH(QDEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx_line),
        .tx       (tx),
        .tx_we    (tx_we),
        .tx_wdata (tx_wdata),
        .tx_full  (tx_full),
        .rx_re    (rx_re),
        .rx_rdata (rx_rdata),
        .rx_ready (rx_ready),
        .rx_full  (rx_full),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_wdata = b;
        tx_we    = 1'b1;
        @(posedge clk);
        #1 tx_we = 1'b0;
    endtask

    task automatic pop_rx();
        rx_re = 1'b1;
        @(posedge clk);
        #1 rx_re = 1'b0;
    endtask

    // Called just after the edge that starts the frame; checks every cycle of it.
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            check(tag, {tx, busy}, {bits[i / CPB], 1'b1});
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int t;

        repeat (5) align();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_flags", {rx_ready, rx_full, tx_full}, 3'b000);
        check("rst_rdata", rx_rdata, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("reset_idle", {tx, busy, rx_ready, tx_full}, 4'b1000);
        end
        align();

        push_tx(8'hA5);
        @(negedge clk);
        check("tx_pre", {tx, busy}, 2'b10);
        @(posedge clk);
        check_frame("tx_a5", 8'hA5);
        @(negedge clk);
        check("tx_after", {tx, busy}, 2'b10);
        align();

        push_tx(8'hFF);
        fork
            begin
                @(posedge clk);
                check_frame("burst_lead", 8'hFF);
                for (int k = 0; k < 16; k++) check_frame($sformatf("burst_%0d", k), 8'(k));
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    if (k == 15) begin
                        @(negedge clk);
                        check("tx_full_at_15", tx_full, 0);
                    end
                    push_tx(8'(k));
                end
                @(negedge clk);
                check("tx_full_at_16", tx_full, 1);
                push_tx(8'h10);
                @(negedge clk);
                check("tx_full_after_17", tx_full, 1);
            end
        join
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("burst_idle", {tx, busy, tx_full}, 3'b100);
        end
        align();

        send_rx(8'h3C, 1'b1);
        repeat (4) align();
        check("rx_ready_3c", rx_ready, 1);
        check("rx_rdata_3c", rx_rdata, 8'h3C);
        check("rx_full_3c", rx_full, 0);
        pop_rx();
        @(negedge clk);
        check("rx_pop_ready", rx_ready, 0);
        check("rx_pop_rdata", rx_rdata, 8'h00);
        align();

        rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (40) align();
        check("rx_glitch", rx_ready, 0);

        send_rx(8'h55, 1'b0);
        repeat (40) align();
        check("rx_framing", rx_ready, 0);

        for (int i = 0; i < 17; i++) begin
            if (i == 16) check("rx_full_at_16", rx_full, 1);
            send_rx(8'h40 + 8'(i), 1'b1);
        end
        repeat (4) align();
        check("rx_full_after_17", rx_full, 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("rx_order_%0d", i), rx_rdata, 8'h40 + 8'(i));
            pop_rx();
        end
        check("rx_drained", {rx_ready, rx_full}, 2'b00);

        loop_en = 1'b1;
        repeat (2) align();
        for (int v = 1; v <= 8; v++) push_tx(8'(v));
        for (t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("loop_timeout", t < 2000, 1);
        repeat (20) align();
        for (int v = 1; v <= 8; v++) begin
            check($sformatf("loop_%0d", v), rx_rdata, 8'(v));
            pop_rx();
        end
        check("loop_drained", rx_ready, 0);

        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        check("mid_rx_timeout", t < 400, 1);
        for (t = 0; t < 100; t++) begin
            if (!tx) break;
            @(negedge clk);
        end
        check("mid_tx_low", tx, 0);
        check("mid_pre", {busy, rx_ready}, 2'b11);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flags", {rx_ready, rx_full, tx_full}, 3'b000);
        check("mid_rst_rdata", rx_rdata, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("post_rst_idle", {tx, busy, rx_ready}, 3'b100);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
